// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer at the front of fetch.
// Owns the PC register and selects the next-PC source each cycle:
// sequential, branch, jump, exception vector, hold or exception return.
// o_pc_sel uses the same 3-bit encoding as the PC source mux, so it also
// serves as a trace signal.
// Optional feature: define PC_SEQ_ALIGN_CHK_EN to enable target alignment
// checking. When it is undefined, targets load verbatim and o_misalign
// stays 0.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_stall,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  input  logic        i_jump,
  input  logic [31:0] i_jump_target,
  input  logic        i_exc_req,
  input  logic        i_eret,
  output logic [31:0] o_pc,
  output logic [2:0]  o_pc_sel,
  output logic        o_flush,
  output logic [31:0] o_epc,
  output logic        o_in_trap,
  output logic        o_misalign
);

  // Next-PC source encodings, shared with the external PC mux.
  localparam logic [2:0] SEL_SEQ  = 3'b000;
  localparam logic [2:0] SEL_BR   = 3'b001;
  localparam logic [2:0] SEL_JMP  = 3'b010;
  localparam logic [2:0] SEL_EXC  = 3'b011;
  localparam logic [2:0] SEL_HOLD = 3'b100;
  localparam logic [2:0] SEL_EPC  = 3'b101;

`ifdef PC_SEQ_ALIGN_CHK_EN
  localparam logic ALIGN_CHK = 1'b1;
`else
  localparam logic ALIGN_CHK = 1'b0;
`endif

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] r_epc;
  logic [31:0] w_epc_next;
  logic [31:0] w_pc_raw;
  logic [31:0] w_pc_next;
  logic [31:0] w_pc_plus4;
  logic [2:0]  w_sel;
  logic        r_flush;
  logic        w_flush_next;
  logic        w_mis_next;
  logic        w_jt_bad;
  logic        w_bt_bad;
  logic        w_epc_bad;

  // Misaligned-target detection; collapses to 0 when checking is disabled.
  assign w_jt_bad  = ALIGN_CHK & (i_jump_target[1:0] != 2'b00);
  assign w_bt_bad  = ALIGN_CHK & (i_branch_target[1:0] != 2'b00);
  assign w_epc_bad = ALIGN_CHK & (r_epc[1:0] != 2'b00);

  // Sequential successor wraps naturally modulo 2^32.
  assign w_pc_plus4 = r_pc + 32'd4;

  // Next-state and select decode; priority order differs between RUN and TRAP.
  always_comb begin
    w_sel        = SEL_SEQ;
    w_state_next = r_state;
    w_epc_next   = r_epc;
    w_mis_next   = 1'b0;
    if (rst) begin
      w_sel = SEL_SEQ;
    end else if (r_state == ST_RUN) begin
      // eret is meaningless outside a handler, so RUN never looks at it.
      if (i_exc_req) begin
        w_sel        = SEL_EXC;
        w_epc_next   = r_pc;
        w_state_next = ST_TRAP;
      end else if (i_stall) begin
        w_sel = SEL_HOLD;
      end else if (i_jump) begin
        if (w_jt_bad) begin
          w_sel        = SEL_EXC;
          w_epc_next   = r_pc;
          w_state_next = ST_TRAP;
          w_mis_next   = 1'b1;
        end else begin
          w_sel = SEL_JMP;
        end
      end else if (i_branch_taken) begin
        if (w_bt_bad) begin
          w_sel        = SEL_EXC;
          w_epc_next   = r_pc;
          w_state_next = ST_TRAP;
          w_mis_next   = 1'b1;
        end else begin
          w_sel = SEL_BR;
        end
      end else begin
        w_sel = SEL_SEQ;
      end
    end else begin
      // No nested exceptions: exc_req is ignored and epc is preserved.
      // Inside the handler a misaligned target cannot trap again, so it
      // is aligned down instead and only flagged.
      if (i_stall) begin
        w_sel = SEL_HOLD;
      end else if (i_eret) begin
        w_sel        = SEL_EPC;
        w_state_next = ST_RUN;
        w_mis_next   = w_epc_bad;
      end else if (i_jump) begin
        w_sel      = SEL_JMP;
        w_mis_next = w_jt_bad;
      end else if (i_branch_taken) begin
        w_sel      = SEL_BR;
        w_mis_next = w_bt_bad;
      end else begin
        w_sel = SEL_SEQ;
      end
    end
  end

  // PC source mux driven by the select; 110/111 are never produced.
  always_comb begin
    w_pc_raw = w_pc_plus4;
    case (w_sel)
      SEL_SEQ:  w_pc_raw = w_pc_plus4;
      SEL_BR:   w_pc_raw = i_branch_target;
      SEL_JMP:  w_pc_raw = i_jump_target;
      SEL_EXC:  w_pc_raw = EXC_VECTOR;
      SEL_HOLD: w_pc_raw = r_pc;
      SEL_EPC:  w_pc_raw = r_epc;
      default:  w_pc_raw = w_pc_plus4;
    endcase
  end

  // A flagged load only reaches the PC inside TRAP (RUN turns it into the
  // exception vector), so forcing the low bits here aligns exactly those.
  assign w_pc_next = w_mis_next ? {w_pc_raw[31:2], 2'b00} : w_pc_raw;

  // Any redirect away from pc+4/hold costs the fetched instruction.
  assign w_flush_next = (w_sel == SEL_BR) || (w_sel == SEL_JMP) ||
                        (w_sel == SEL_EXC) || (w_sel == SEL_EPC);

  // State, PC, EPC and flush registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_pc    <= RESET_VECTOR;
      r_epc   <= 32'h0000_0000;
      r_flush <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_epc   <= w_epc_next;
      r_flush <= w_flush_next;
    end
  end

`ifdef PC_SEQ_ALIGN_CHK_EN
  logic r_misalign;

  // One-cycle pulse marking a misaligned target that was trapped or aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_mis_next;
    end
  end

  assign o_misalign = r_misalign;
`else
  assign o_misalign = 1'b0;
`endif

  assign o_pc      = r_pc;
  assign o_pc_sel  = w_sel;
  assign o_flush   = r_flush;
  assign o_epc     = r_epc;
  assign o_in_trap = (r_state == ST_TRAP);

endmodule
